snake_head_motion: RTL and testbench

//  Upstream stage of the VGA colour mapper: owns player-1 snake-head position and heading.

---
 rtl/snake_head_motion.sv | 213 +++++++++++++++++++++
 tb/tb_snake_head_motion.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_head_motion.sv
`default_nettype none
// ============================================================================
//  Module   : snake_head_motion
//  Purpose  : Player-1 snake head position/heading for the VGA colour mapper.
//             Decodes WASD keys into a latched heading, steps the head one grid
//             cell every STEP_FRAMES vsync frames, flags death on wall contact
//             and restarts on Space.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_head_motion #(
    parameter int STEP_FRAMES = 4,
    parameter int STEP_PX     = 24,
    parameter int X_START     = 324,
    parameter int Y_START     = 240,
    parameter int X_MIN       = 12,
    parameter int X_MAX       = 627,
    parameter int Y_MIN       = 12,
    parameter int Y_MAX       = 467
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] snakeX_pos,
    output logic [9:0] snakeY_pos,
    output logic [9:0] snake_size,
    output logic [1:0] motionFlag,
    output logic       step_pulse,
    output logic       dead
);

    // Frame counter sizing; a single-frame step still needs one bit.
    localparam int              c_CNT_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEP_FRAMES - 1);

    // Step arithmetic is done in 11-bit signed so underflow shows up as negative.
    localparam logic signed [10:0] c_STEP  = 11'(STEP_PX);
    localparam logic signed [10:0] c_X_MIN = 11'(X_MIN);
    localparam logic signed [10:0] c_X_MAX = 11'(X_MAX);
    localparam logic signed [10:0] c_Y_MIN = 11'(Y_MIN);
    localparam logic signed [10:0] c_Y_MAX = 11'(Y_MAX);

    localparam logic [9:0] c_X_START = 10'(X_START);
    localparam logic [9:0] c_Y_START = 10'(Y_START);
    localparam logic [9:0] c_HALF_W  = 10'd12;

    // Keycodes
    localparam logic [7:0] c_KEY_W       = 8'h1A;
    localparam logic [7:0] c_KEY_A       = 8'h04;
    localparam logic [7:0] c_KEY_S       = 8'h16;
    localparam logic [7:0] c_KEY_D       = 8'h07;
    localparam logic [7:0] c_KEY_RESTART = 8'h2C;

    // Headings: 0=up, 1=left, 2=down, 3=right; opposite heading = heading ^ 2.
    localparam logic [1:0] c_DIR_W = 2'd0;
    localparam logic [1:0] c_DIR_A = 2'd1;
    localparam logic [1:0] c_DIR_S = 2'd2;
    localparam logic [1:0] c_DIR_D = 2'd3;

    // FSM encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_MOVING = 2'd1;
    localparam logic [1:0] c_DEAD   = 2'd2;

    logic               r_sync1, r_sync2;
    logic [1:0]         r_state, w_state_nxt;
    logic [9:0]         r_x, w_x_nxt;
    logic [9:0]         r_y, w_y_nxt;
    logic [1:0]         r_motion, w_motion_nxt;
    logic [1:0]         r_pending, w_pending_nxt;
    logic [c_CNT_W-1:0] r_count, w_count_nxt;
    logic               r_pulse, w_pulse_nxt;
    logic               r_dead, w_dead_nxt;

    logic               w_key_valid;
    logic [1:0]         w_key_dir;
    logic               w_key_legal;
    logic               w_key_restart;
    logic               w_frame_tick;
    logic               w_step_due;
    logic signed [10:0] w_x_ext, w_y_ext;
    logic signed [10:0] w_x_step, w_y_step;
    logic               w_step_legal;

    assign w_frame_tick  = r_sync1 & ~r_sync2;
    assign w_step_due    = w_frame_tick && (r_count == c_CNT_LAST);
    assign w_key_restart = (keycode == c_KEY_RESTART);
    // A key is only accepted into pending if it does not reverse the current heading.
    assign w_key_legal   = w_key_valid && (w_key_dir != (r_motion ^ 2'd2));

    assign w_x_ext = $signed({1'b0, r_x});
    assign w_y_ext = $signed({1'b0, r_y});
    assign w_step_legal = (w_x_step >= c_X_MIN) && (w_x_step <= c_X_MAX) &&
                          (w_y_step >= c_Y_MIN) && (w_y_step <= c_Y_MAX);

    assign snakeX_pos = r_x;
    assign snakeY_pos = r_y;
    assign snake_size = c_HALF_W;
    assign motionFlag = r_motion;
    assign step_pulse = r_pulse;
    assign dead       = r_dead;

    // Two-flop synchroniser for the vsync level (rising edge detected from the flop pair).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
        end
    end

    // WASD keycode to heading decode.
    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = c_DIR_W;
        case (keycode)
            c_KEY_W: w_key_dir = c_DIR_W;
            c_KEY_A: w_key_dir = c_DIR_A;
            c_KEY_S: w_key_dir = c_DIR_S;
            c_KEY_D: w_key_dir = c_DIR_D;
            default: w_key_valid = 1'b0;
        endcase
    end

    // Candidate next head position along the pending heading.
    always_comb begin
        w_x_step = w_x_ext;
        w_y_step = w_y_ext;
        case (r_pending)
            c_DIR_W: w_y_step = w_y_ext - c_STEP;
            c_DIR_A: w_x_step = w_x_ext - c_STEP;
            c_DIR_S: w_y_step = w_y_ext + c_STEP;
            default: w_x_step = w_x_ext + c_STEP;
        endcase
    end

    // Next-state and next-output logic for the IDLE/MOVING/DEAD machine.
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_motion_nxt  = r_motion;
        w_pending_nxt = w_key_legal ? w_key_dir : r_pending;
        w_count_nxt   = r_count;
        w_pulse_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // The first key sets heading directly, with no reversal check.
                if (w_key_valid) begin
                    w_state_nxt   = c_MOVING;
                    w_motion_nxt  = w_key_dir;
                    w_pending_nxt = w_key_dir;
                    w_count_nxt   = '0;
                end
            end
            c_MOVING: begin
                if (w_frame_tick) begin
                    w_count_nxt = (r_count == c_CNT_LAST) ? '0 : r_count + c_CNT_W'(1);
                end
                // The step uses pending as it stood before this cycle's key.
                if (w_step_due) begin
                    w_motion_nxt = r_pending;
                    if (w_step_legal) begin
                        w_x_nxt     = w_x_step[9:0];
                        w_y_nxt     = w_y_step[9:0];
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_DEAD;
                    end
                end
            end
            c_DEAD: begin
                if (w_key_restart) begin
                    w_state_nxt   = c_IDLE;
                    w_x_nxt       = c_X_START;
                    w_y_nxt       = c_Y_START;
                    w_motion_nxt  = c_DIR_D;
                    w_pending_nxt = c_DIR_D;
                    w_count_nxt   = '0;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
        w_dead_nxt = (w_state_nxt == c_DEAD);
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_IDLE;
            r_x       <= c_X_START;
            r_y       <= c_Y_START;
            r_motion  <= c_DIR_D;
            r_pending <= c_DIR_D;
            r_count   <= '0;
            r_pulse   <= 1'b0;
            r_dead    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_motion  <= w_motion_nxt;
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_pulse   <= w_pulse_nxt;
            r_dead    <= w_dead_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_head_motion.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_head_motion
//  Purpose  : Self-checking bench for snake_head_motion: a cycle model built
//             from the movement rules plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snake_head_motion;

    localparam int c_STEP_FRAMES = 4;
    localparam int c_STEP_PX     = 24;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] snakeX_pos, snakeY_pos, snake_size;
    logic [1:0] motionFlag;
    logic       step_pulse, dead;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;

    snake_head_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .snakeX_pos (snakeX_pos),
        .snakeY_pos (snakeY_pos),
        .snake_size (snake_size),
        .motionFlag (motionFlag),
        .step_pulse (step_pulse),
        .dead       (dead)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 moving, 2 dead. Heading: 0 up, 1 left, 2 down, 3 right.
    int m_x, m_y, m_dir, m_pend, m_frames, m_mode;
    bit m_pulse, m_h1, m_h2;

    function automatic bit decode(input logic [7:0] k, output int d);
        d = 0;
        case (k)
            8'h1A: begin d = 0; return 1; end
            8'h04: begin d = 1; return 1; end
            8'h16: begin d = 2; return 1; end
            8'h07: begin d = 3; return 1; end
            default: return 0;
        endcase
    endfunction

    function automatic bit reverses(input int a, input int b);
        return ((a + 2) % 4) == b;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_x = 324; m_y = 240; m_dir = 3; m_pend = 3;
            m_frames = 0; m_mode = 0; m_pulse = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            bit tick, kv;
            int k, new_pend, nx, ny;
            // vsync rising edge as seen through the synchroniser
            tick = m_h1 && !m_h2;
            m_h2 = m_h1;
            m_h1 = frame_clk;
            kv = decode(keycode, k);
            new_pend = (kv && !reverses(k, m_dir)) ? k : m_pend;
            m_pulse = 0;
            if (m_mode == 0) begin
                m_pend = new_pend;
                if (kv) begin
                    m_mode = 1; m_dir = k; m_pend = k; m_frames = 0;
                end
            end else if (m_mode == 1) begin
                if (tick) begin
                    m_frames++;
                    if (m_frames == c_STEP_FRAMES) begin
                        m_frames = 0;
                        m_dir = m_pend;
                        nx = m_x + ((m_pend == 3) ? c_STEP_PX : (m_pend == 1) ? -c_STEP_PX : 0);
                        ny = m_y + ((m_pend == 2) ? c_STEP_PX : (m_pend == 0) ? -c_STEP_PX : 0);
                        if (nx >= 12 && nx <= 627 && ny >= 12 && ny <= 467) begin
                            m_x = nx; m_y = ny; m_pulse = 1;
                        end else begin
                            m_mode = 2;
                        end
                    end
                end
                m_pend = new_pend;
            end else begin
                m_pend = new_pend;
                if (keycode == 8'h2C) begin
                    m_mode = 0; m_x = 324; m_y = 240; m_dir = 3; m_pend = 3; m_frames = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        check("x", 32'(snakeX_pos), 32'(m_x));
        check("y", 32'(snakeY_pos), 32'(m_y));
        check("dir", 32'(motionFlag), 32'(m_dir));
        check("pulse", 32'(step_pulse), 32'(m_pulse));
        check("dead", 32'(dead), 32'(m_mode == 2));
        check("size", 32'(snake_size), 32'd12);
        if (step_pulse === 1'b1) pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic frames(input int n);
        repeat (n) begin
            @(posedge Clk); #2 frame_clk = 1'b1;
            repeat (3) @(posedge Clk);
            #2 frame_clk = 1'b0;
            repeat (4) @(posedge Clk);
        end
    endtask

    task automatic press(input logic [7:0] k);
        @(posedge Clk); #2 keycode = k;
        @(posedge Clk); #2 keycode = 8'h00;
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge Clk); #2 Reset = 1'b1;
        @(posedge Clk); #2 Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b0;

        // 1: idle, no keys, 10 frames
        check("t1_reset_x", 32'(snakeX_pos), 32'd324);
        base = pulses;
        frames(10);
        check("t1_x", 32'(snakeX_pos), 32'd324);
        check("t1_y", 32'(snakeY_pos), 32'd240);
        check("t1_dir", 32'(motionFlag), 32'd3);
        check("t1_pulses", 32'(pulses - base), 32'd0);
        check("t1_dead", 32'(dead), 32'd0);

        // 2: W from idle, 8 frames -> two steps up
        press(8'h1A);
        base = pulses;
        frames(8);
        check("t2_y", 32'(snakeY_pos), 32'd192);
        check("t2_x", 32'(snakeX_pos), 32'd324);
        check("t2_dir", 32'(motionFlag), 32'd0);
        check("t2_pulses", 32'(pulses - base), 32'd2);

        // 3: fresh start heading D, reverse key A ignored
        pulse_reset();
        press(8'h07);
        press(8'h04);
        frames(4);
        check("t3_x", 32'(snakeX_pos), 32'd348);
        check("t3_dir", 32'(motionFlag), 32'd3);

        // 4: run right into the wall at X_MAX; Space while moving is ignored
        press(8'h2C);
        frames(44);
        check("t4_x612", 32'(snakeX_pos), 32'd612);
        base = pulses;
        frames(4);
        check("t4_dead", 32'(dead), 32'd1);
        check("t4_x_hold", 32'(snakeX_pos), 32'd612);
        check("t4_nopulse", 32'(pulses - base), 32'd0);
        frames(2);
        check("t4_frozen", 32'(snakeX_pos), 32'd612);
        press(8'h2C);
        check("t4_restart_dead", 32'(dead), 32'd0);
        check("t4_restart_x", 32'(snakeX_pos), 32'd324);
        check("t4_restart_y", 32'(snakeY_pos), 32'd240);

        // 4b: left to X_MIN exactly, then the underflowing step kills
        press(8'h04);
        frames(52);
        check("t4b_xmin", 32'(snakeX_pos), 32'd12);
        check("t4b_alive", 32'(dead), 32'd0);
        frames(4);
        check("t4b_dead", 32'(dead), 32'd1);
        check("t4b_x_hold", 32'(snakeX_pos), 32'd12);
        check("t4b_dir", 32'(motionFlag), 32'd1);
        press(8'h2C);

        // 5: heading W, S rejected then D taken within one interval
        press(8'h1A);
        check("t5_dir_w", 32'(motionFlag), 32'd0);
        press(8'h16);
        press(8'h07);
        frames(4);
        check("t5_x", 32'(snakeX_pos), 32'd348);
        check("t5_y", 32'(snakeY_pos), 32'd240);
        check("t5_dir", 32'(motionFlag), 32'd3);

        // 6: asynchronous reset mid-move at (420,240)
        frames(13);
        check("t6_x_pre", 32'(snakeX_pos), 32'd420);
        @(posedge Clk); #2 Reset = 1'b1;
        #1;
        check("t6_async_x", 32'(snakeX_pos), 32'd324);
        check("t6_async_y", 32'(snakeY_pos), 32'd240);
        check("t6_async_dir", 32'(motionFlag), 32'd3);
        check("t6_async_dead", 32'(dead), 32'd0);
        @(posedge Clk); #2 Reset = 1'b0;
        frames(5);
        check("t6_idle_x", 32'(snakeX_pos), 32'd324);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
